pin_attempt_ctrl: RTL
=====================

# pin_attempt_ctrl

Session and lockout controller that sits between the user switch panel and the `DebitPin` checker. It forwards one-hot digit entries as clean single-cycle submit pulses, issues a checker reset before every attempt and judges the checker's verdict. It counts failed attempts and locks the panel out after `MAX_TRIES` failures. It is the only driver of `DebitPin`'s `digit_switches`, `submit` and `reset` inputs.

## Interface
- `MAX_TRIES`, 3: failed attempts before lockout, ≥1.
- `LOCK_CYCLES`, 16: lockout duration in cycles, ≥1.
- `RESULT_TIMEOUT`, 8: cycles allowed for the checker verdict after the 4th digit.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `user_digits` in 4: digit switches, valid only if one-hot.
- `user_submit` in 1: raw submit level from the panel.
- `chk_digits` out 4: to `DebitPin.digit_switches`.
- `chk_submit` out 1: one-cycle pulse to `DebitPin.submit`.
- `chk_reset` out 1: to `DebitPin.reset`.
- `chk_waiting`, `chk_correct`, `chk_incorrect`, `chk_bug` in 1 each: `DebitPin` status.
- `unlocked` out 1: access granted.
- `locked_out` out 1: lockout active.
- `fail_count` out `$clog2(MAX_TRIES+1)`: consecutive failures.
- `fault` out 1: sticky checker fault.

## Operation
- The block detects rising edges of `user_submit` using a registered previous sample. Holding the line high produces a single edge.
- States and transitions:
  - **INIT**: asserts `chk_reset` and clears the digit counter. Always moves to ENTRY after 1 cycle.
  - **ENTRY**: an edge with one-hot `user_digits` is accepted. The block registers `user_digits` into `chk_digits` and pulses `chk_submit`. Edges with non-one-hot digits are ignored and produce no pulse. After the 4th accepted digit the FSM moves to WAIT_RESULT.
  - **WAIT_RESULT**: edges are ignored and the timeout counter runs. The first cycle with any status high decides the next state:
    - `chk_bug`, or `chk_correct` and `chk_incorrect` together → FAULT.
    - `chk_correct` → GRANTED.
    - `chk_incorrect` → FAILED.
    - No verdict after `RESULT_TIMEOUT` cycles → FAULT.
  - **GRANTED**: `unlocked`=1 and `fail_count` is cleared. The next rising edge of `user_submit` (logout) → INIT.
  - **FAILED**: 1 cycle. `fail_count`+1. If the new value equals `MAX_TRIES`, go to LOCKED; otherwise go to INIT.
  - **LOCKED**: `locked_out`=1 and all edges are ignored. The lock counter counts `LOCK_CYCLES` cycles, then clears `fail_count` → INIT.
  - **FAULT**: `fault`=1, `chk_submit` is never asserted and `chk_reset` is held high. The block leaves FAULT only on `reset`.
- `fail_count` saturates at `MAX_TRIES` and never wraps.

## Timing
- Reset values: `chk_digits`=0, `chk_submit`=0, `chk_reset`=1, `unlocked`=0, `locked_out`=0, `fail_count`=0, `fault`=0. The FSM enters INIT on the cycle after `reset` falls.
- Reset asserted mid-operation aborts the attempt and clears all counters, the lock and the fault.
- An edge sampled at posedge N produces `chk_digits` valid at N+1 together with `chk_submit`=1 for exactly that one cycle. `chk_digits` holds until the next accepted digit.
- Minimum spacing between accepted digits is 2 cycles. An edge during the `chk_submit` cycle is dropped.
- Verdict latency: the status seen at posedge N produces the state output (`unlocked`, `fail_count` update or `fault`) at N+1.
- Exact lockout window: `locked_out` is high for exactly `LOCK_CYCLES` cycles, followed by 1 cycle of `chk_reset` and then ENTRY.

## Configuration
- `PIN_LOCK_LATCH_EN`:
  - Defined: LOCKED is permanent until `reset`, and `LOCK_CYCLES` is unused.
  - Undefined: LOCKED times out as described in Operation.

## Structure
- Package `pin_ctrl_pkg` holds:
  - the state enum `pin_ctrl_state_t`;
  - one-hot digit constants `DIG0`..`DIG3`;
  - the function `is_onehot4`;
  - the `PIN_LEN`=4 constant.
- Sub-module `submit_edge_det`: a registered rising-edge detector on `user_submit` with synchronous reset.

## Test plan
- Checker passkey 4'b1010; enter digits 0001,0001,0100,0100 (`DebitPin` encodes 2'b00,00,10,10) → 4 single `chk_submit` pulses, then `unlocked`=1 and `fail_count`=0.
- Wrong PIN entered 3 times → `fail_count` goes 1, 2, 3. `locked_out`=1 for exactly 16 cycles, then `chk_reset` pulses and `fail_count`=0.
- `user_submit` held high 10 cycles with `user_digits`=0110 → no `chk_submit` pulses and the digit counter stays 0. Repeat with 0100 → exactly one pulse.
- Force `chk_bug`=1 in WAIT_RESULT → `fault`=1 from the next cycle, `chk_reset`=1, submits ignored until `reset`.
- No verdict for 8 cycles after the 4th digit → FAULT. `reset` during LOCKED → INIT next cycle with `locked_out`=0 and `fail_count`=0.
- With `PIN_LOCK_LATCH_EN` defined and 3 failures → `locked_out` stays 1 for more than 100 cycles and clears only on `reset`.

Source files
------------

// File: rtl/pin_ctrl_pkg.sv
// Shared types and constants for the PIN attempt controller.
// Pure declarations: no clocked logic, no flow control.
package pin_ctrl_pkg;

  localparam int PIN_LEN = 4;

  localparam logic [3:0] DIG0 = 4'b0001;
  localparam logic [3:0] DIG1 = 4'b0010;
  localparam logic [3:0] DIG2 = 4'b0100;
  localparam logic [3:0] DIG3 = 4'b1000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ENTRY,
    ST_WAIT_RESULT,
    ST_GRANTED,
    ST_FAILED,
    ST_LOCKED,
    ST_FAULT
  } pin_ctrl_state_t;

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/submit_edge_det.sv
// Rising-edge detector on the raw panel submit level; previous sample is registered.
// Latency: combinational pulse in the cycle the new high level is sampled; no backpressure.
module submit_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/pin_attempt_ctrl.sv
// Session/lockout controller in front of the DebitPin checker; PIN_LOCK_LATCH_EN makes lockout permanent until reset.
// Latency: accepted digit -> chk_submit next cycle; checker verdict -> state output next cycle.
// Backpressure: none; panel edges arriving outside ENTRY or during a chk_submit cycle are dropped.
module pin_attempt_ctrl
  import pin_ctrl_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int RESULT_TIMEOUT = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         user_digits,
  input  logic                               user_submit,
  output logic [3:0]                         chk_digits,
  output logic                               chk_submit,
  output logic                               chk_reset,
  input  logic                               chk_waiting,
  input  logic                               chk_correct,
  input  logic                               chk_incorrect,
  input  logic                               chk_bug,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count,
  output logic                               fault
);

  localparam int FC_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W = $clog2(RESULT_TIMEOUT + 1);
  localparam int DC_W = $clog2(PIN_LEN);

  pin_ctrl_state_t state_q, state_d;
  logic [DC_W-1:0] dig_cnt_q, dig_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [FC_W-1:0] fail_q, fail_d;
  logic [3:0]      digits_q, digits_d;
  logic            submit_q, submit_d;
  logic            rise;

  // chk_waiting only reports an idle checker; it never carries a verdict.
  logic unused_chk_waiting;
  assign unused_chk_waiting = chk_waiting;

`ifdef PIN_LOCK_LATCH_EN
  localparam int unused_lock_cycles = LOCK_CYCLES;
`else
  localparam int LK_W = $clog2(LOCK_CYCLES + 1);
  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

  submit_edge_det u_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (user_submit),
    .rise_o  (rise)
  );

  always_comb begin
    state_d   = state_q;
    dig_cnt_d = dig_cnt_q;
    to_cnt_d  = '0;
    fail_d    = fail_q;
    digits_d  = digits_q;
    submit_d  = 1'b0;
`ifndef PIN_LOCK_LATCH_EN
    lock_cnt_d = '0;
`endif
    unique case (state_q)
      ST_INIT: begin
        dig_cnt_d = '0;
        state_d   = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (rise && is_onehot4(user_digits) && !submit_q) begin
          digits_d  = user_digits;
          submit_d  = 1'b1;
          dig_cnt_d = dig_cnt_q + 1'b1;
          if (dig_cnt_q == DC_W'(PIN_LEN - 1)) state_d = ST_WAIT_RESULT;
        end
      end
      ST_WAIT_RESULT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (chk_bug || (chk_correct && chk_incorrect)) begin
          state_d = ST_FAULT;
        end else if (chk_correct) begin
          fail_d  = '0;
          state_d = ST_GRANTED;
        end else if (chk_incorrect) begin
          // Count lands with the FAILED state so the verdict shows one cycle later.
          if (fail_q != FC_W'(MAX_TRIES)) fail_d = fail_q + 1'b1;
          state_d = ST_FAILED;
        end else if (to_cnt_q == TO_W'(RESULT_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end
      end
      ST_GRANTED: begin
        fail_d = '0;
        if (rise) state_d = ST_INIT;
      end
      ST_FAILED: begin
        state_d = (fail_q == FC_W'(MAX_TRIES)) ? ST_LOCKED : ST_INIT;
      end
      ST_LOCKED: begin
`ifndef PIN_LOCK_LATCH_EN
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (lock_cnt_q == LK_W'(LOCK_CYCLES - 1)) begin
          fail_d  = '0;
          state_d = ST_INIT;
        end
`endif
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      dig_cnt_q <= '0;
      to_cnt_q  <= '0;
      fail_q    <= '0;
      digits_q  <= '0;
      submit_q  <= 1'b0;
`ifndef PIN_LOCK_LATCH_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dig_cnt_q <= dig_cnt_d;
      to_cnt_q  <= to_cnt_d;
      fail_q    <= fail_d;
      digits_q  <= digits_d;
      submit_q  <= submit_d;
`ifndef PIN_LOCK_LATCH_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign chk_digits = digits_q;
  assign chk_submit = submit_q;
  assign chk_reset  = (state_q == ST_INIT) || (state_q == ST_FAULT);
  assign unlocked   = (state_q == ST_GRANTED);
  assign locked_out = (state_q == ST_LOCKED);
  assign fault      = (state_q == ST_FAULT);
  assign fail_count = fail_q;

endmodule
